// File: rtl/csl_seq_pkg.sv
// Shared types and constants for the console-switch sequencer.
// The state encoding and command codes are used by both the RTL and its bench.
package csl_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] CMD_RUN  = 2'd0;
    localparam logic [1:0] CMD_HALT = 2'd1;
    localparam logic [1:0] CMD_CONT = 2'd2;
    localparam logic [1:0] CMD_EXEC = 2'd3;

    // Bit order of the returned vector is {EXEC, CONT, HALT, RUN}.
    function automatic logic [3:0] cmd_onehot(input logic [1:0] code);
        logic [3:0] v;
        case (code)
            CMD_RUN:  v = 4'b0001;
            CMD_HALT: v = 4'b0010;
            CMD_CONT: v = 4'b0100;
            CMD_EXEC: v = 4'b1000;
            default:  v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/csl_seq.sv
// Console switch sequencer: raises one csl* request for exactly one CPU sampling
// edge, then waits (with timeout) for the matching CPU status acknowledge.
module csl_seq
    import csl_seq_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TOW     = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_code,
    output logic       cmd_ready,
    input  logic       cpuRUN,
    input  logic       cpuHALT,
    input  logic       cpuCONT,
    input  logic       cpuEXEC,
    output logic       cslRUN,
    output logic       cslHALT,
    output logic       cslCONT,
    output logic       cslEXEC,
    output logic       done,
    output logic       err
);

    localparam logic [TOW-1:0] CNT_LAST = TOW'(TIMEOUT - 1);

    state_t         state_r, state_s;
    logic [1:0]     code_r, code_s;
    logic           seen_r, seen_s;
    logic [TOW-1:0] cnt_r, cnt_s;
    logic           err_r, err_s;
    logic [3:0]     csl_r, csl_s;
    logic           done_r, done_s;
    logic           ready_r, ready_s;
    logic [3:0]     cpu_s;
    logic           track_s;
    logic           ack_s;
    logic           tmo_s;

    assign cpu_s   = {cpuEXEC, cpuCONT, cpuHALT, cpuRUN};
    assign track_s = cpu_s[code_r];

    // Next-state, acknowledge/timeout evaluation and next output values.
    always_comb begin
        state_s = state_r;
        code_s  = code_r;
        seen_s  = seen_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        ack_s   = 1'b0;
        tmo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    code_s  = cmd_code;
                    err_s   = 1'b0;
                    seen_s  = 1'b0;
                    cnt_s   = '0;
                    state_s = ST_ASSERT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                seen_s = seen_r | track_s;
                if (clken) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ASSERT;
                end
            end
            ST_WAIT: begin
                seen_s = seen_r | track_s;
                // CONT/EXEC finish on the falling side of a status pulse already seen.
                case (code_r)
                    CMD_RUN, CMD_HALT: ack_s = track_s;
                    default:           ack_s = seen_r & ~track_s;
                endcase
                if (clken) begin
                    cnt_s = cnt_r + TOW'(1);
                    tmo_s = (cnt_r == CNT_LAST);
                end else begin
                    cnt_s = cnt_r;
                    tmo_s = 1'b0;
                end
                if (ack_s) begin
                    state_s = ST_DONE;
                end else if (tmo_s) begin
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (state_s == ST_ASSERT) begin
            csl_s = cmd_onehot(code_s);
        end else begin
            csl_s = 4'b0000;
        end
        done_s  = (state_s == ST_DONE);
        ready_s = (state_s == ST_IDLE);
    end

    // State, command context and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            code_r  <= 2'd0;
            seen_r  <= 1'b0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            csl_r   <= 4'b0000;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            code_r  <= code_s;
            seen_r  <= seen_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            csl_r   <= csl_s;
            done_r  <= done_s;
            ready_r <= ready_s;
        end
    end

    assign cslRUN    = csl_r[0];
    assign cslHALT   = csl_r[1];
    assign cslCONT   = csl_r[2];
    assign cslEXEC   = csl_r[3];
    assign done      = done_r;
    assign err       = err_r;
    assign cmd_ready = ready_r;

endmodule

// File: tb/tb_csl_seq.sv
// Self-checking bench for csl_seq: directed scenarios plus randomized commands
// predicted from the acknowledge/timeout rules by a transaction-level model.
module tb_csl_seq;
    import csl_seq_pkg::*;

    localparam int TO    = 16;
    localparam int LIMIT = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clken = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_code = 2'd0;
    logic       cmd_ready;
    logic       cpuRUN = 1'b0, cpuHALT = 1'b0, cpuCONT = 1'b0, cpuEXEC = 1'b0;
    logic       cslRUN, cslHALT, cslCONT, cslEXEC;
    logic       done, err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic done_prev = 1'b0;
    logic [3:0] mon_csl;

    always #5 clk = ~clk;

    csl_seq #(.TIMEOUT(TO), .TOW(5)) dut (
        .clk(clk), .rst(rst), .clken(clken),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
        .cpuRUN(cpuRUN), .cpuHALT(cpuHALT), .cpuCONT(cpuCONT), .cpuEXEC(cpuEXEC),
        .cslRUN(cslRUN), .cslHALT(cslHALT), .cslCONT(cslCONT), .cslEXEC(cslEXEC),
        .done(done), .err(err)
    );

    // Invariants checked every cycle.
    always @(negedge clk) begin
        mon_csl = {cslEXEC, cslCONT, cslHALT, cslRUN};
        checks = checks + 3;
        assert ($countones(mon_csl) <= 1) else begin
            errors++; $error("FAIL csl_onehot observed=%b expected=at-most-one-set", mon_csl);
        end
        assert (!(done && done_prev)) else begin
            errors++; $error("FAIL done_consecutive observed=1 expected=0");
        end
        assert (!((mon_csl != 4'b0000) && (cmd_ready || done))) else begin
            errors++; $error("FAIL csl_outside_assert observed=%b expected=0000", mon_csl);
        end
        if (done) done_cnt++;
        done_prev = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic clk_for(input int idx, input int per, input int ph, input int stall);
        if (idx < stall) return 1'b0;
        else if (per <= 1) return 1'b1;
        else return ((idx + ph) % per) == 0;
    endfunction

    task automatic drive_cpu(input logic [1:0] code, input logic v);
        cpuRUN  = (code == CMD_RUN)  ? v : 1'b0;
        cpuHALT = (code == CMD_HALT) ? v : 1'b0;
        cpuCONT = (code == CMD_CONT) ? v : 1'b0;
        cpuEXEC = (code == CMD_EXEC) ? v : 1'b0;
    endtask

    function automatic logic cpu_bit(input logic [1:0] code);
        logic [3:0] v;
        v = {cpuEXEC, cpuCONT, cpuHALT, cpuRUN};
        return v[code];
    endfunction

    // One complete command; the CPU reacts d cycles after the sampling edge and,
    // for CONT/EXEC, drops its status w cycles later.
    task automatic run_cmd(input logic [1:0] code, input int per, input int ph, input int d,
                           input int w, input bit never, input bit pre, input int stall,
                           input bit hold_valid, output int s_out, output bit err_out);
        int S, kw, done_e, pred, done_before, csl_hi;
        bit fin, seen_b, ack, bitv, exp_err, level;
        logic [3:0] exp_csl, c;
        exp_csl = 4'b0001 << code;
        S = -1; kw = 0; done_e = -1; fin = 1'b0; seen_b = 1'b0; exp_err = 1'b0; csl_hi = 0;
        done_before = done_cnt;
        cmd_code = code; cmd_valid = 1'b1;
        drive_cpu(code, pre);
        clken = clk_for(0, per, ph, stall);
        for (int e = 0; e < LIMIT && !fin; e++) begin
            bitv = cpu_bit(code);
            if (e == 0) begin
                seen_b = 1'b0;
            end else if (S < 0) begin
                if (bitv) seen_b = 1'b1;
                if (clken) S = e;
            end else begin
                ack = (code == CMD_RUN || code == CMD_HALT) ? bitv : (seen_b && !bitv);
                if (bitv) seen_b = 1'b1;
                if (clken) kw++;
                if (ack) begin fin = 1'b1; exp_err = 1'b0; done_e = e; end
                else if (kw == TO) begin fin = 1'b1; exp_err = 1'b1; done_e = e; end
            end
            step();
            if (!hold_valid) cmd_valid = 1'b0;
            c = {cslEXEC, cslCONT, cslHALT, cslRUN};
            if (c != 4'b0000) csl_hi++;
            chk("csl", 32'(c), (S < 0) ? 32'(exp_csl) : 32'd0);
            chk("done", 32'(done), 32'(fin));
            chk("ready_busy", 32'(cmd_ready), 32'd0);
            chk("err", 32'(err), 32'(fin && exp_err));
            clken = clk_for(e + 1, per, ph, stall);
            if (fin) begin
                level = 1'b0;
            end else if (code == CMD_RUN || code == CMD_HALT) begin
                level = pre || (!never && S >= 0 && e >= S + d);
            end else begin
                level = !never && S >= 0 && e >= S + d && e < S + d + w;
            end
            drive_cpu(code, level);
        end
        chk("finished_in_budget", 32'(fin), 32'd1);
        pred = (code == CMD_RUN || code == CMD_HALT) ? (pre ? S + 1 : S + d + 1) : S + d + w + 1;
        if (fin && !exp_err) chk("done_edge", 32'(done_e), 32'(pred));
        if (fin && exp_err && !never) chk("timeout_before_ack", 32'(pred > done_e), 32'd1);
        if (fin && exp_err && per == 1) chk("timeout_edge", 32'(done_e), 32'(S + TO));
        chk("csl_cycles", 32'(csl_hi), 32'(S));
        step();
        chk("done_after", 32'(done), 32'd0);
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        chk("err_sticky", 32'(err), 32'(exp_err));
        chk("done_count", 32'(done_cnt - done_before), 32'd1);
        s_out = S;
        err_out = exp_err;
    endtask

    initial begin
        int s;
        bit e;
        int dc;
        logic [1:0] rc;
        bit got;

        step(); step();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_csl", 32'({cslEXEC, cslCONT, cslHALT, cslRUN}), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        step();

        // RUN with sparse clken, CPU answers 3 cycles after sampling.
        run_cmd(CMD_RUN, 4, 1, 3, 0, 1'b0, 1'b0, 0, 1'b0, s, e);
        chk("run_csl_range", 32'(s >= 1 && s <= 4), 32'd1);
        chk("run_err", 32'(e), 32'd0);

        // EXEC pulse of 20 cycles starting on the sampling edge.
        run_cmd(CMD_EXEC, 4, 2, 0, 20, 1'b0, 1'b0, 0, 1'b0, s, e);

        // HALT never acknowledged: timeout, then next command clears err.
        run_cmd(CMD_HALT, 1, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0, s, e);
        chk("halt_timeout_err", 32'(e), 32'd1);
        run_cmd(CMD_CONT, 2, 0, 1, 3, 1'b0, 1'b0, 0, 1'b0, s, e);
        chk("err_cleared", 32'(e), 32'd0);

        // Acknowledge on the very edge the counter expires.
        run_cmd(CMD_RUN, 1, 0, TO - 1, 0, 1'b0, 1'b0, 0, 1'b0, s, e);
        chk("tie_ack_wins", 32'(e), 32'd0);

        // Acknowledge already present when WAIT is entered.
        run_cmd(CMD_RUN, 3, 0, 0, 0, 1'b0, 1'b1, 0, 1'b0, s, e);

        // clken held low for a long stretch keeps the request asserted.
        run_cmd(CMD_HALT, 1, 0, 2, 0, 1'b0, 1'b0, 30, 1'b0, s, e);
        chk("stall_assert_len", 32'(s), 32'd30);

        // cmd_valid held high: exactly one CONT, the next accepted only after done.
        run_cmd(CMD_CONT, 2, 1, 1, 4, 1'b0, 1'b0, 0, 1'b1, s, e);
        step();
        chk("second_accept_csl", 32'(cslCONT), 32'd1);
        chk("second_accept_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        drive_cpu(CMD_CONT, 1'b0);
        clken = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = done;
        end
        chk("second_cont_done", 32'(got), 32'd1);
        chk("second_cont_err", 32'(err), 32'd1);
        step();

        // Reset while cslHALT is high.
        cmd_code = CMD_HALT; cmd_valid = 1'b1; clken = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("pre_reset_halt", 32'(cslHALT), 32'd1);
        dc = done_cnt;
        #1 rst = 1'b0;
        #1;
        chk("async_halt_drop", 32'(cslHALT), 32'd0);
        chk("async_ready", 32'(cmd_ready), 32'd1);
        chk("async_done", 32'(done), 32'd0);
        step(); step();
        rst = 1'b1;
        step(); step();
        chk("post_reset_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_no_done", 32'(done_cnt), 32'(dc));

        // Randomized commands.
        for (int k = 0; k < 24; k++) begin
            rc = 2'($urandom_range(3, 0));
            run_cmd(rc, int'($urandom_range(4, 1)), int'($urandom_range(3, 0)),
                    int'($urandom_range(6, 0)), int'($urandom_range(12, 1)),
                    ($urandom_range(7, 0) == 0), ((rc == CMD_RUN || rc == CMD_HALT) && $urandom_range(3, 0) == 0),
                    ($urandom_range(5, 0) == 0) ? int'($urandom_range(10, 1)) : 0, 1'b0, s, e);
            if ($urandom_range(1, 0) == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csl_seq.md
CSL_SEQ -- requirements
Module: csl_seq

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum clken-qualified cycles to wait for CPU acknowledge.
REQ-002 Parameter TOW, default 11: timeout counter width; SHALL hold TIMEOUT.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 clken  in  1  CPU clock enable; the CPU samples csl* only when this is 1.
REQ-006 cmd_valid  in  1  host command request.
REQ-007 cmd_code  in  2  command: 0=RUN, 1=HALT, 2=CONT, 3=EXEC.
REQ-008 cmd_ready  out  1  sequencer idle; a command is accepted when cmd_valid&cmd_ready.
REQ-009 cpuRUN, cpuHALT, cpuCONT, cpuEXEC  in  1 each  CPU status feedback.
REQ-010 cslRUN, cslHALT, cslCONT, cslEXEC  out  1 each  console switch requests to the CPU.
REQ-011 done  out  1  one-cycle pulse at command completion (success or timeout).
REQ-012 err  out  1  sticky timeout flag; cleared on the next accepted command.

Function
REQ-013 FSM states: IDLE, ASSERT, WAIT, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: on cmd_valid, latch cmd_code, clear err, clear the seen flag and counter, go to ASSERT on the next edge.
REQ-015 ASSERT: the csl* output selected by the latched code SHALL be 1, and all others 0.
REQ-016 ASSERT SHALL persist until an edge with clken=1 has occurred, so that the CPU samples the request exactly once; the next state is WAIT and the csl* output drops on that same edge.
REQ-017 At most one csl* output SHALL be 1 in any cycle, and only in ASSERT.
REQ-018 WAIT acknowledge conditions: RUN completes when cpuRUN=1; HALT completes when cpuHALT=1.
REQ-019 WAIT acknowledge conditions: CONT completes when cpuCONT has been seen 1 and is now 0; EXEC completes when cpuEXEC has been seen 1 and is now 0.
REQ-020 Seen flag: set in ASSERT or WAIT whenever the tracked status bit is 1.
REQ-021 Timeout counter: increments on each clken=1 cycle in WAIT; reaching TIMEOUT with no acknowledge sets err and goes to DONE.
REQ-022 If acknowledge and timeout occur in the same cycle, acknowledge wins and err stays 0.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 cmd_valid is ignored outside IDLE; no queuing.
REQ-025 Acknowledge already true on entry to WAIT (e.g. RUN while cpuRUN=1) SHALL complete in the first WAIT cycle.
REQ-026 With clken held 0, the sequencer SHALL remain in ASSERT indefinitely; the counter does not advance.

Reset
REQ-027 rst=0 SHALL asynchronously force state=IDLE, all csl*=0, done=0, err=0, counter=0, seen=0 and latched code=0.
REQ-028 Reset mid-command SHALL drop any asserted csl* immediately; the command is lost and no done pulse is produced.

Structure
REQ-029 Package csl_seq_pkg SHALL hold the state encoding and the cmd_code constants (CMD_RUN, CMD_HALT, CMD_CONT, CMD_EXEC).
REQ-030 Single module; no sub-module is needed, and the timeout counter is inline.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 RUN, clken=1 every 4th cycle, CPU model sets cpuRUN 3 cycles after the sampling edge -> cslRUN high 1-4 cycles, done once, err=0.
REQ-033 EXEC, model sets cpuEXEC on the sampling edge and clears it 20 cycles later -> done in the cycle after the clear is observed, not before.
REQ-034 HALT with a model that never sets cpuHALT, TIMEOUT=16, clken=1 -> done after 16 WAIT cycles, err=1; the next command clears err.
REQ-035 cmd_valid held high through a whole CONT sequence -> exactly one command executes, and the second is accepted only after done.
REQ-036 rst driven low while cslHALT=1 -> cslHALT=0 with no clock edge, done never pulses, cmd_ready=1 after reset release.
REQ-037 Assertion checks: csl* one-hot-or-zero at all times; done never in consecutive cycles; csl* never 1 outside ASSERT.
